video_timing_ctrl: RTL
======================

Name: video_timing_ctrl

Overview:
- Master raster sequencer for the video path; drives the horizontal and vertical counters that feed the sync generator.
- The sync generator consumes the counter bits plus the line/frame reset strobes to build HBLANK/HSYNC/VBLANK/VSYNC.
- Replaces the original ripple-counter chain with a fully synchronous design clocked by CLK_DRV.
- A pixel clock-enable is derived internally, so CLK_DRV may run faster than the pixel rate.

Parameters:
- H_TOTAL, 454, pixel counts per line; HCNT runs 0..H_TOTAL-1.
- V_TOTAL, 262, lines per frame; VCNT runs 0..V_TOTAL-1.
- CLK_DIV, 1, CLK_DRV cycles per pixel (>=1); 1 = PIX_CE tied high.

Ports:
- CLK_DRV  in  1  system clock; sole clock of the block
- RESET  in  1  synchronous, active-high reset
- HOLD  in  1  freeze raster at current position when high
- PIX_CE  out  1  pixel clock enable, one CLK_DRV cycle wide
- HCNT  out  9  horizontal count; bit n = _(2^n)H, e.g. HCNT[4] = _16H
- VCNT  out  9  vertical count; bit n = _(2^n)V
- HRESET_N  out  1  low during last pixel of line (HCNT == H_TOTAL-1)
- VRESET  out  1  high for entire last line (VCNT == V_TOTAL-1)
- LINE_START  out  1  one-CLK_DRV pulse on the PIX_CE that wraps HCNT to 0
- FRAME_START  out  1  one-CLK_DRV pulse on the PIX_CE that wraps HCNT and VCNT to 0

Behaviour:
- Single clock domain. Reset is synchronous and active-high: RESET is sampled on posedge CLK_DRV.
- Reset state: divider = 0, HCNT = 0, VCNT = 0, PIX_CE = 0 (1 if CLK_DIV = 1), HRESET_N = 1, VRESET = 0, LINE_START = 0, FRAME_START = 0.
- RESET wins over HOLD and over any wrap event in the same cycle.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - PIX_CE is high when divider == CLK_DIV-1.
  - Divider still runs while HOLD is high; only counter advance is gated.
- Horizontal step: on posedge CLK_DRV with PIX_CE=1 and HOLD=0:
  - HCNT == H_TOTAL-1 -> HCNT <= 0 and a vertical step occurs.
  - Otherwise HCNT <= HCNT+1.
- Vertical step:
  - VCNT == V_TOTAL-1 -> VCNT <= 0.
  - Otherwise VCNT <= VCNT+1.
  - VCNT changes only in the same cycle HCNT wraps.
- HRESET_N and VRESET:
  - Combinational decode of the registered counters; no extra latency.
  - HRESET_N is low for exactly CLK_DIV CLK_DRV cycles per line when HOLD = 0.
  - VRESET is high for H_TOTAL*CLK_DIV cycles per frame.
- LINE_START and FRAME_START are combinational: PIX_CE & ~HOLD & wrap condition.
  - Each asserts in the cycle before the counters read 0.
  - FRAME_START implies LINE_START.
- HOLD:
  - Counters and decoded outputs stay static; LINE_START and FRAME_START are forced low.
  - Releasing HOLD resumes from the held position; no pixel is skipped or duplicated.
- Widths:
  - H_TOTAL and V_TOTAL must be <= 512.
  - Counters never hold values >= TOTAL.
  - Out-of-range parameters are a static error (elaboration-time check).
- Reset mid-frame: next cycle returns to the reset state; a partial line or frame is abandoned with no stale strobes.

Optional Feature:
- Macro: FRAME_CNT_EN.
- Defined:
  - Adds output FRAME_CNT[7:0], reset to 0.
  - Increments by 1 (wrapping 255 -> 0) on each cycle FRAME_START = 1; used for attract-mode timing and debug.
  - Adds output FIELD_ODD = FRAME_CNT[0].
- Undefined:
  - Neither port exists; no frame counter logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset values: hold RESET 3 cycles, then release.
  - Required: HCNT=0, VCNT=0, HRESET_N=1, VRESET=0, strobes 0.
  - With CLK_DIV=1: HCNT=1 after the first post-reset edge.
- Horizontal wrap (CLK_DIV=1): run 454 cycles from reset.
  - HCNT=453 with HRESET_N=0 and LINE_START=1 in the same cycle.
  - Next cycle: HCNT=0, VCNT=1, HRESET_N=1.
- Vertical wrap: run 454*262 cycles.
  - VRESET=1 while VCNT=261 for exactly 454 cycles.
  - FRAME_START=1 at HCNT=453/VCNT=261; next cycle HCNT=0, VCNT=0.
- CLK_DIV=3: PIX_CE high 1 of every 3 cycles.
  - HCNT increments only on PIX_CE.
  - HRESET_N low for exactly 3 cycles per line.
  - Line period = 1362 cycles.
- HOLD and mid-frame reset:
  - Assert HOLD at HCNT=100, VCNT=50 for 20 cycles: counters frozen and strobes 0; on release, next PIX_CE gives HCNT=101.
  - Assert RESET at HCNT=300, VCNT=200 coincident with PIX_CE: next cycle all at reset state.
- FRAME_CNT_EN build: run 3 full frames from reset.
  - FRAME_CNT=3, FIELD_ODD=1.
  - FRAME_CNT wraps from 255 to 0 on frame 256.

Source files
------------

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: pixel divider, horizontal/vertical counters and line/frame strobes on CLK_DRV.
// Optional frame counter (FRAME_CNT, FIELD_ODD) is built only when FRAME_CNT_EN is defined.
module video_timing_ctrl #(
    parameter int H_TOTAL = 454,
    parameter int V_TOTAL = 262,
    parameter int CLK_DIV = 1
) (
    input  logic       CLK_DRV,
    input  logic       RESET,
    input  logic       HOLD,
    output logic       PIX_CE,
    output logic [8:0] HCNT,
    output logic [8:0] VCNT,
    output logic       HRESET_N,
    output logic       VRESET,
    output logic       LINE_START,
`ifdef FRAME_CNT_EN
    output logic       FRAME_START,
    output logic [7:0] FRAME_CNT,
    output logic       FIELD_ODD
`else
    output logic       FRAME_START
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

    if (H_TOTAL < 1 || H_TOTAL > 512 || V_TOTAL < 1 || V_TOTAL > 512 || CLK_DIV < 1) begin : g_bad_param
        $error("video_timing_ctrl: H_TOTAL/V_TOTAL must be 1..512 and CLK_DIV >= 1");
    end

    logic [DIV_W-1:0] div_q;
    logic             h_last;
    logic             v_last;
    logic             step;

    // The divider keeps running under HOLD so the pixel phase is preserved across a hold.
    assign PIX_CE = (div_q == DIV_LAST);
    assign h_last = (HCNT == H_LAST);
    assign v_last = (VCNT == V_LAST);
    assign step   = PIX_CE & ~HOLD;

    assign HRESET_N    = ~h_last;
    assign VRESET      = v_last;
    assign LINE_START  = step & h_last;
    assign FRAME_START = step & h_last & v_last;

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            div_q <= '0;
            HCNT  <= '0;
            VCNT  <= '0;
        end else begin
            div_q <= PIX_CE ? '0 : div_q + 1'b1;
            if (step) begin
                if (h_last) begin
                    HCNT <= '0;
                    VCNT <= v_last ? 9'd0 : VCNT + 9'd1;
                end else begin
                    HCNT <= HCNT + 9'd1;
                end
            end
        end
    end

`ifdef FRAME_CNT_EN
    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            FRAME_CNT <= '0;
        end else if (FRAME_START) begin
            FRAME_CNT <= FRAME_CNT + 8'd1;
        end
    end

    assign FIELD_ODD = FRAME_CNT[0];
`endif

endmodule
